// File: rtl/operand_entry_scan.sv
// rtl/operand_entry_scan.sv - debounced operand entry and digit-scan generator
//
// Purpose: turns three raw pushbuttons into single-step edits of two 3-bit
// operands and produces the alternating display select for the comparator.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_a_inc  in   raw button, increments A (mod 8)
//   btn_b_inc  in   raw button, increments B (mod 8)
//   btn_clr    in   raw button, clears A and B (wins over increments)
//   A, B       out  registered operands
//   sel        out  registered display select, 0 = A, 1 = B
//   upd        out  one-cycle pulse after A and/or B is written
module operand_entry_scan #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SCAN_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a_inc,
  input  logic       btn_b_inc,
  input  logic       btn_clr,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       sel,
  output logic       upd
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  localparam logic [1:0] S_RELEASED    = 2'd0;
  localparam logic [1:0] S_PRESS_CHK   = 2'd1;
  localparam logic [1:0] S_HELD        = 2'd2;
  localparam logic [1:0] S_RELEASE_CHK = 2'd3;

  // Button index: 0 = A increment, 1 = B increment, 2 = clear.
  logic [2:0]       w_btn_raw;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_press;
  logic [1:0]       r_state [3];
  logic [CNT_W-1:0] r_cnt   [3];

  logic [2:0]        r_a;
  logic [2:0]        r_b;
  logic              r_upd;
  logic              r_sel;
  logic [SCAN_W-1:0] r_scan_cnt;

  assign w_btn_raw = {btn_clr, btn_b_inc, btn_a_inc};

  // Two-flop synchronizers feed the debounce FSMs; the raw buttons are
  // never used anywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= S_RELEASED;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        case (r_state[i])
          S_RELEASED: begin
            if (r_sync2[i]) begin
              r_state[i] <= S_PRESS_CHK;
              r_cnt[i]   <= '0;
            end
          end
          S_PRESS_CHK: begin
            if (!r_sync2[i]) begin
              r_state[i] <= S_RELEASED;
            end else if (r_cnt[i] == CNT_LAST) begin
              // Only this transition produces a pulse, so holding never repeats.
              r_state[i] <= S_HELD;
              r_press[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          S_HELD: begin
            if (!r_sync2[i]) begin
              r_state[i] <= S_RELEASE_CHK;
              r_cnt[i]   <= '0;
            end
          end
          S_RELEASE_CHK: begin
            // A short low dip returns to HELD silently.
            if (r_sync2[i]) begin
              r_state[i] <= S_HELD;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_state[i] <= S_RELEASED;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            r_state[i] <= S_RELEASED;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Operand registers; clear beats both increments in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_upd <= 1'b0;
    end else begin
      r_upd <= |r_press;
      if (r_press[2]) begin
        r_a <= '0;
        r_b <= '0;
      end else begin
        if (r_press[0]) r_a <= r_a + 3'd1;
        if (r_press[1]) r_b <= r_b + 3'd1;
      end
    end
  end

  // Free-running scan: sel toggles on each counter wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_sel      <= 1'b0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_sel      <= ~r_sel;
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  assign A   = r_a;
  assign B   = r_b;
  assign sel = r_sel;
  assign upd = r_upd;

endmodule

// File: tb/tb_operand_entry_scan.sv
// tb/tb_operand_entry_scan.sv - scoreboard bench for operand_entry_scan
module tb_operand_entry_scan;

  localparam int DEB  = 4;
  localparam int SCAN = 3;
  localparam int LAT  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_a_inc = 1'b0;
  logic       btn_b_inc = 1'b0;
  logic       btn_clr = 1'b0;
  logic [2:0] A;
  logic [2:0] B;
  logic       sel;
  logic       upd;

  operand_entry_scan #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_a_inc(btn_a_inc),
    .btn_b_inc(btn_b_inc),
    .btn_clr  (btn_clr),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   n_scan = 0;
  bit   scan_ok = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      n_scan  <= 0;
      scan_ok <= 1'b1;
    end else begin
      n_scan <= n_scan + 1;
    end
  end

  // Monitor: checks sel every cycle and pops the scoreboard on each upd.
  always @(negedge clk) begin
    if (scan_ok) begin
      logic exp_sel;
      exp_t e;
      exp_sel = ((n_scan / SCAN) % 2) == 1;
      n_cmp++;
      if (sel !== exp_sel) begin
        n_bad++;
        $display("FAIL sel cyc=%0d got=%b want=%b", cyc, sel, exp_sel);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL upd_missing want_cyc=%0d now=%0d", e.cyc, cyc);
      end
      if (upd === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL upd_unexpected cyc=%0d A=%0d B=%0d", cyc, A, B);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || A !== e.a || B !== e.b) begin
            n_bad++;
            $display("FAIL upd_value got cyc=%0d A=%0d B=%0d want cyc=%0d A=%0d B=%0d",
                     cyc, A, B, e.cyc, e.a, e.b);
          end
        end
      end else if (upd !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL upd_x cyc=%0d got=%b want=0", cyc, upd);
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_A", A, 3'd0);
    chk("rst_B", B, 3'd0);
    chk("rst_upd", {2'b0, upd}, 3'd0);
    chk("rst_sel", {2'b0, sel}, 3'd0);
    rst = 1'b0;
  endtask

  // mask = {clr, b, a}; an expected update is scheduled LAT edges after
  // the first edge that samples the buttons high.
  task automatic press(input logic [2:0] mask, input int hold, input int low,
                       input bit want_upd, input logic [2:0] ea, input logic [2:0] eb);
    int k;
    @(negedge clk);
    {btn_clr, btn_b_inc, btn_a_inc} = mask;
    k = cyc + 1;
    if (want_upd) exp_q.push_back('{k + LAT, ea, eb});
    repeat (hold) @(negedge clk);
    {btn_clr, btn_b_inc, btn_a_inc} = 3'b000;
    repeat (low) @(negedge clk);
  endtask

  logic [2:0] seq3 [9];

  initial begin
    int k;
    seq3 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    // 1: single held press increments once
    do_reset();
    press(3'b001, 50, 15, 1'b1, 3'd1, 3'd0);
    chk("t1_A", A, 3'd1);
    chk("t1_B", B, 3'd0);

    // 2: short pulse ignored; short dip while held does not re-trigger
    press(3'b010, 4, 12, 1'b0, 3'd0, 3'd0);
    chk("t2_glitch_B", B, 3'd0);
    @(negedge clk);
    btn_b_inc = 1'b1;
    k = cyc + 1;
    exp_q.push_back('{k + LAT, 3'd1, 3'd1});
    repeat (20) @(negedge clk);
    btn_b_inc = 1'b0;
    repeat (2) @(negedge clk);
    btn_b_inc = 1'b1;
    repeat (20) @(negedge clk);
    btn_b_inc = 1'b0;
    repeat (15) @(negedge clk);
    chk("t2_B", B, 3'd1);

    // 3: nine presses wrap modulo 8
    do_reset();
    for (int i = 0; i < 9; i++) press(3'b001, 10, 12, 1'b1, seq3[i], 3'd0);
    chk("t3_A", A, 3'd1);

    // 4: simultaneous presses, clear priority
    press(3'b011, 10, 12, 1'b1, 3'd2, 3'd1);
    press(3'b011, 10, 12, 1'b1, 3'd3, 3'd2);
    press(3'b010, 10, 12, 1'b1, 3'd3, 3'd3);
    press(3'b010, 10, 12, 1'b1, 3'd3, 3'd4);
    press(3'b010, 10, 12, 1'b1, 3'd3, 3'd5);
    press(3'b111, 10, 12, 1'b1, 3'd0, 3'd0);
    press(3'b011, 10, 12, 1'b1, 3'd1, 3'd1);
    press(3'b011, 10, 12, 1'b1, 3'd2, 3'd2);
    press(3'b011, 10, 12, 1'b1, 3'd3, 3'd3);
    press(3'b010, 10, 12, 1'b1, 3'd3, 3'd4);
    press(3'b010, 10, 12, 1'b1, 3'd3, 3'd5);
    press(3'b011, 10, 12, 1'b1, 3'd4, 3'd6);
    chk("t4_A", A, 3'd4);
    chk("t4_B", B, 3'd6);

    // 5: scan from a fresh reset while buttons toggle (sel checked by monitor)
    do_reset();
    press(3'b001, 2, 3, 1'b0, 3'd0, 3'd0);
    press(3'b010, 3, 2, 1'b0, 3'd0, 3'd0);
    press(3'b100, 4, 4, 1'b0, 3'd0, 3'd0);
    press(3'b011, 1, 8, 1'b0, 3'd0, 3'd0);

    // 6: reset in the middle of PRESS_CHK with the button still held
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk);
    btn_a_inc = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_A", A, 3'd0);
    chk("t6_rst_sel", {2'b0, sel}, 3'd0);
    rst = 1'b0;
    k = cyc + 1;
    exp_q.push_back('{k + LAT, 3'd1, 3'd0});
    repeat (30) @(negedge clk);
    btn_a_inc = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6_A", A, 3'd1);

    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
